// File: rtl/cw_sequencer.sv
// ---------------------------------------------------------------------------
// cw_sequencer
//
// Purpose:
//   Micro-sequencer for a multi-cycle CPU. It latches an instruction into
//   the instruction register, presents the instruction and the current
//   micro-step to external decoders, and gates the control word coming back
//   from those decoders onto the datapath control outputs. It also stalls on
//   slow RAM accesses, counts retired instructions, and runs a watchdog that
//   halts the machine when one instruction runs too many micro-steps.
//
// Ports:
//   clock        in   single clock, all state changes on its rising edge
//   reset        in   synchronous active-high reset
//   instr[31:0]  in   instruction word from instruction memory
//   instr_valid  in   instr is valid this cycle
//   cw_in[32:0]  in   control word decoded from ir and state
//   ram_ready    in   RAM access completes this cycle
//   ir[31:0]     out  registered instruction for the decoders
//   state[1:0]   out  registered micro-step for the decoders
//   alu_en .. status_ld
//                out  control-word fields, gated by the sequencer
//   fetch        out  sequencer is waiting for an instruction
//   retired      out  number of completed instructions (wraps)
//   fault        out  sticky watchdog fault, cleared only by reset
// ---------------------------------------------------------------------------
module cw_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [32:0] cw_in,
    input  logic        ram_ready,
    output logic [31:0] ir,
    output logic [1:0]  state,
    output logic        alu_en,
    output logic        alu_bs,
    output logic [4:0]  alu_fs,
    output logic        rf_b_en,
    output logic [4:0]  rf_sa,
    output logic [4:0]  rf_sb,
    output logic [4:0]  rf_da,
    output logic        rf_w,
    output logic        ram_en,
    output logic        ram_w,
    output logic        pc_en,
    output logic [1:0]  pc_fs,
    output logic        pc_is,
    output logic        status_ld,
    output logic        fetch,
    output logic [31:0] retired,
    output logic        fault
);

    typedef enum logic [1:0] {
        FSM_FETCH = 2'd0,
        FSM_EXEC  = 2'd1,
        FSM_HALT  = 2'd2
    } fsm_e;

    // Field view of the decoder control word, MSB first.
    typedef struct packed {
        logic       alu_en;
        logic       alu_bs;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] rf_sa;
        logic [4:0] rf_sb;
        logic [4:0] rf_da;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_is;
        logic       status_ld;
        logic [1:0] next_state;
    } cw_t;

    // Watchdog limit: a non-retiring step taken with the counter already at
    // this value means the instruction has run too long.
    localparam logic [2:0] WDOG_LIMIT = 3'd7;

    cw_t         cw;
    cw_t         ctl;
    logic        stall;

    fsm_e        fsm_q,     fsm_d;
    logic [31:0] ir_q,      ir_d;
    logic [1:0]  step_q,    step_d;
    logic [2:0]  wdog_q,    wdog_d;
    logic [31:0] retired_q, retired_d;
    logic        fault_q,   fault_d;

    assign cw = cw_in;

    // Next-state and control gating. Outside EXEC every control output is
    // held at zero. A stall keeps the memory request visible but suppresses
    // the side effects that must happen exactly once (register write, PC
    // update, status load) until the RAM completes.
    always_comb begin
        fsm_d     = fsm_q;
        ir_d      = ir_q;
        step_d    = step_q;
        wdog_d    = wdog_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        ctl       = '0;
        stall     = 1'b0;

        case (fsm_q)
            FSM_FETCH: begin
                if (instr_valid) begin
                    ir_d   = instr;
                    step_d = 2'd0;
                    fsm_d  = FSM_EXEC;
                end
            end

            FSM_EXEC: begin
                ctl            = cw;
                ctl.next_state = 2'd0;
                stall          = cw.ram_en & ~ram_ready;
                if (stall) begin
                    ctl.rf_w      = 1'b0;
                    ctl.pc_en     = 1'b0;
                    ctl.status_ld = 1'b0;
                end else if (cw.next_state == 2'd0) begin
                    retired_d = retired_q + 32'd1;
                    wdog_d    = 3'd0;
                    step_d    = 2'd0;
                    fsm_d     = FSM_FETCH;
                end else if (wdog_q == WDOG_LIMIT) begin
                    // Micro-step is frozen so the offending step stays visible.
                    fault_d = 1'b1;
                    fsm_d   = FSM_HALT;
                end else begin
                    step_d = cw.next_state;
                    wdog_d = wdog_q + 3'd1;
                end
            end

            FSM_HALT: begin
                fault_d = 1'b1;
            end

            default: begin
                fsm_d = FSM_FETCH;
            end
        endcase
    end

    // State register. Reset wins over any fetch, step or stall in the same
    // cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q     <= FSM_FETCH;
            ir_q      <= 32'd0;
            step_q    <= 2'd0;
            wdog_q    <= 3'd0;
            retired_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            ir_q      <= ir_d;
            step_q    <= step_d;
            wdog_q    <= wdog_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    assign ir        = ir_q;
    assign state     = step_q;
    assign fetch     = (fsm_q == FSM_FETCH);
    assign retired   = retired_q;
    assign fault     = fault_q;

    assign alu_en    = ctl.alu_en;
    assign alu_bs    = ctl.alu_bs;
    assign alu_fs    = ctl.alu_fs;
    assign rf_b_en   = ctl.rf_b_en;
    assign rf_sa     = ctl.rf_sa;
    assign rf_sb     = ctl.rf_sb;
    assign rf_da     = ctl.rf_da;
    assign rf_w      = ctl.rf_w;
    assign ram_en    = ctl.ram_en;
    assign ram_w     = ctl.ram_w;
    assign pc_en     = ctl.pc_en;
    assign pc_fs     = ctl.pc_fs;
    assign pc_is     = ctl.pc_is;
    assign status_ld = ctl.status_ld;

endmodule

// File: tb/tb_cw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cw_sequencer
//
// Purpose:
//   Self-checking bench for cw_sequencer. A behavioural model of the
//   sequencer rules predicts every output each cycle; directed sequences
//   cover branch, stalled load, watchdog, reset during stall, counter wrap
//   and idle fetch, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_cw_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic [32:0] cw_in;
    logic        ram_ready;
    logic [31:0] ir;
    logic [1:0]  state;
    logic        alu_en;
    logic        alu_bs;
    logic [4:0]  alu_fs;
    logic        rf_b_en;
    logic [4:0]  rf_sa;
    logic [4:0]  rf_sb;
    logic [4:0]  rf_da;
    logic        rf_w;
    logic        ram_en;
    logic        ram_w;
    logic        pc_en;
    logic [1:0]  pc_fs;
    logic        pc_is;
    logic        status_ld;
    logic        fetch;
    logic [31:0] retired;
    logic        fault;

    cw_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cw_in       (cw_in),
        .ram_ready   (ram_ready),
        .ir          (ir),
        .state       (state),
        .alu_en      (alu_en),
        .alu_bs      (alu_bs),
        .alu_fs      (alu_fs),
        .rf_b_en     (rf_b_en),
        .rf_sa       (rf_sa),
        .rf_sb       (rf_sb),
        .rf_da       (rf_da),
        .rf_w        (rf_w),
        .ram_en      (ram_en),
        .ram_w       (ram_w),
        .pc_en       (pc_en),
        .pc_fs       (pc_fs),
        .pc_is       (pc_is),
        .status_ld   (status_ld),
        .fetch       (fetch),
        .retired     (retired),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = waiting for instruction, 1 = executing,
    // 2 = halted by watchdog.
    int          m_mode;
    logic [31:0] m_ir;
    logic [1:0]  m_step;
    int          m_steps_taken;
    logic [31:0] m_retired;
    logic        m_fault;

    // Observation counters used by directed sequences.
    int pc_en_cycles;
    int rf_w_cycles;
    int exec_cycles;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode        = 0;
        m_ir          = 32'd0;
        m_step        = 2'd0;
        m_steps_taken = 0;
        m_retired     = 32'd0;
        m_fault       = 1'b0;
    endtask

    // Drive one cycle of inputs, check all outputs against the model, then
    // advance the model across the coming rising edge.
    task automatic apply_stimulus(input logic v, input logic [31:0] ins,
                                  input logic [32:0] cw, input logic rdy,
                                  input logic rst);
        logic [30:0] exp_ctl;
        logic [30:0] got_ctl;
        logic        stalled;
        logic [1:0]  ns;

        @(negedge clock);
        instr_valid = v;
        instr       = ins;
        cw_in       = cw;
        ram_ready   = rdy;
        reset       = rst;
        #1;

        stalled = (m_mode == 1) && cw[8] && !rdy;
        exp_ctl = (m_mode == 1) ? cw[32:2] : 31'd0;
        if (stalled) begin
            exp_ctl[7] = 1'b0;
            exp_ctl[4] = 1'b0;
            exp_ctl[0] = 1'b0;
        end
        got_ctl = {alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da,
                   rf_w, ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld};

        check_output("fetch",    64'(fetch),   64'(m_mode == 0));
        check_output("state",    64'(state),   64'(m_step));
        check_output("ir",       64'(ir),      64'(m_ir));
        check_output("retired",  64'(retired), 64'(m_retired));
        check_output("fault",    64'(fault),   64'(m_fault));
        check_output("controls", 64'(got_ctl), 64'(exp_ctl));

        pc_en_cycles += int'(pc_en);
        rf_w_cycles  += int'(rf_w);
        exec_cycles  += int'(!fetch && !fault);

        ns = cw[1:0];
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (v) begin
                m_ir   = ins;
                m_step = 2'd0;
                m_mode = 1;
            end
        end else if (m_mode == 1 && !stalled) begin
            if (ns == 2'd0) begin
                m_retired     = m_retired + 32'd1;
                m_steps_taken = 0;
                m_step        = 2'd0;
                m_mode        = 0;
            end else if (m_steps_taken >= 7) begin
                m_fault = 1'b1;
                m_mode  = 2;
            end else begin
                m_step        = ns;
                m_steps_taken = m_steps_taken + 1;
            end
        end
    endtask

    task automatic clear_counters();
        pc_en_cycles = 0;
        rf_w_cycles  = 0;
        exec_cycles  = 0;
    endtask

    initial begin
        logic [32:0] rcw;
        logic [31:0] wrap_val;

        instr       = 32'd0;
        instr_valid = 1'b0;
        cw_in       = 33'd0;
        ram_ready   = 1'b0;
        reset       = 1'b1;
        clear_counters();
        repeat (2) @(posedge clock);
        model_reset();

        // Reset state visible after release.
        apply_stimulus(1'b0, 32'h0, 33'h0, 1'b0, 1'b0);

        // Single-step branch.
        clear_counters();
        apply_stimulus(1'b1, 32'hCAFE_0001, 33'h0_0000_0068, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0,         33'h0_0000_0068, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0,         33'h0_0000_0068, 1'b1, 1'b0);
        check_output("branch_pc_en_cycles", 64'(pc_en_cycles), 64'd1);
        check_output("branch_retired",      64'(retired),      64'd1);

        // Two-step load with three stall cycles.
        clear_counters();
        apply_stimulus(1'b1, 32'h1234_5678, 33'h0_0000_0001, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0,         33'h0_0000_0001, 1'b1, 1'b0);
        repeat (3) apply_stimulus(1'b0, 32'h0, 33'h0_0000_0300, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0,         33'h0_0000_0300, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0,         33'h0,           1'b0, 1'b0);
        check_output("load_exec_cycles", 64'(exec_cycles), 64'd5);
        check_output("load_rf_w_cycles", 64'(rf_w_cycles), 64'd1);
        check_output("load_retired",     64'(retired),     64'd2);

        // Idle fetch: nothing changes for ten cycles.
        repeat (10) apply_stimulus(1'b0, $urandom, 33'h1_FFFF_FFFF, 1'b1, 1'b0);
        check_output("idle_ir",      64'(ir),      64'h1234_5678);
        check_output("idle_retired", 64'(retired), 64'd2);

        // Watchdog: next_state stuck at 1, all other control bits set.
        apply_stimulus(1'b1, 32'hDEAD_BEEF, 33'h1_FFFF_FEFD, 1'b1, 1'b0);
        repeat (8) apply_stimulus(1'b0, 32'h0, 33'h1_FFFF_FEFD, 1'b1, 1'b0);
        repeat (4) apply_stimulus(1'b0, 32'h0, 33'h1_FFFF_FFFD, 1'b0, 1'b0);
        check_output("wdog_fault", 64'(fault), 64'd1);
        check_output("wdog_state", 64'(state), 64'd1);

        // Reset while halted, then reset in the middle of a stall.
        apply_stimulus(1'b0, 32'h0, 33'h0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 32'hA5A5_A5A5, 33'h0_0000_0001, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 33'h0_0000_0001, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 33'h1_FFFF_FFFC, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 33'h1_FFFF_FFFC, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 33'h1_FFFF_FFFC, 1'b0, 1'b0);
        check_output("rst_stall_fetch", 64'(fetch), 64'd1);
        check_output("rst_stall_ir",    64'(ir),    64'd0);

        // Counter wrap: preload retired while idling in fetch.
        wrap_val = 32'hFFFF_FFFF;
        apply_stimulus(1'b0, 32'h0, 33'h0, 1'b0, 1'b0);
        @(negedge clock);
        force dut.retired_q = wrap_val;
        @(posedge clock);
        #1;
        release dut.retired_q;
        m_retired = wrap_val;
        apply_stimulus(1'b0, 32'h0, 33'h0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0BAD_F00D, 33'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 33'h0_0000_0044, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 33'h0, 1'b1, 1'b0);
        check_output("wrap_retired", 64'(retired), 64'd0);

        // Randomized run.
        for (int i = 0; i < 1500; i++) begin
            rcw = {1'($urandom), $urandom};
            if ($urandom_range(0, 2) != 0) rcw[1:0] = 2'd0;
            apply_stimulus(($urandom_range(0, 9) < 7), $urandom, rcw,
                           ($urandom_range(0, 9) < 6),
                           ($urandom_range(0, 99) < 2));
        end
        apply_stimulus(1'b0, 32'h0, 33'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cw_sequencer.md
CW_SEQUENCER -- requirements
Module: cw_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port instr, input, 32 bits: instruction word from instruction memory.
REQ-004 SHALL have port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-005 SHALL have port cw_in, input, 33 bits: control word from the decoders, which decode ir and state. Field layout, MSB first: alu_en[32], alu_bs[31], alu_fs[30:26], rf_b_en[25], rf_sa[24:20], rf_sb[19:15], rf_da[14:10], rf_w[9], ram_en[8], ram_w[7], pc_en[6], pc_fs[5:4], pc_is[3], status_ld[2], next_state[1:0].
REQ-006 SHALL have port ram_ready, input, 1 bit: RAM access completes this cycle.
REQ-007 SHALL have port ir, output, 32 bits: registered instruction fed to the decoders.
REQ-008 SHALL have port state, output, 2 bits: registered micro-step fed to the decoders.
REQ-009 SHALL have one output per control-word field, named and sized as in REQ-005, excluding next_state.
REQ-010 SHALL have port fetch, output, 1 bit: the FSM is in FETCH.
REQ-011 SHALL have port retired, output, 32 bits: count of completed instructions.
REQ-012 SHALL have port fault, output, 1 bit: sticky watchdog fault.

Function
REQ-013 SHALL implement the FSM states FETCH, EXEC and HALT.
REQ-014 In FETCH with instr_valid=1: ir <= instr, state <= 0, next state EXEC.
REQ-015 In FETCH with instr_valid=0: remain in FETCH and hold ir.
REQ-016 In FETCH and HALT, all control outputs SHALL be 0.
REQ-017 In EXEC, control outputs SHALL equal the corresponding cw_in fields, subject to REQ-018.
REQ-018 Stall = EXEC and cw_in.ram_en=1 and ram_ready=0.
- During stall: rf_w, pc_en and status_ld forced to 0; all other fields pass through.
- state and ir held.
REQ-019 EXEC, no stall, next_state=0:
- go to FETCH;
- retired <= retired+1, wrapping from 0xFFFFFFFF to 0;
- step counter cleared.
REQ-020 EXEC, no stall, next_state!=0:
- state <= next_state, remain in EXEC;
- 3-bit step counter incremented.
REQ-021 A non-retiring step taken with step counter = 7 SHALL raise fault and enter HALT instead of continuing.
REQ-022 Stalled cycles SHALL NOT advance the step counter.
REQ-023 HALT SHALL be left only by reset; fault remains 1 while in HALT.
REQ-024 Latency: one FETCH cycle plus one cycle per non-stalled micro-step; a single-step instruction retires 2 cycles after acceptance.
REQ-025 next_state is consumed only by the FSM and SHALL NOT be driven out.

Reset
REQ-026 On reset=1 at a clock edge:
- FSM <= FETCH; ir, state, retired, step counter <= 0; fault <= 0;
- reset SHALL override every other event in that cycle, including mid-EXEC and stall.
REQ-027 While in reset state, control outputs SHALL be 0 and fetch SHALL be 1.

Verification
REQ-028 Single-step branch:
- Stimulus: instr_valid=1; in EXEC, cw_in has pc_en=1, pc_fs=2'b10, pc_is=1, next_state=0.
- Required: pc_en=1 for exactly one cycle; retired 0->1; fetch=1 on the next cycle.
REQ-029 Two-step load:
- Stimulus: step 0 next_state=2'b01; step 1 ram_en=1, rf_w=1, next_state=0; ram_ready=0 for 3 cycles, then 1.
- Required: rf_w=0 during the 3 stall cycles, 1 on the completing cycle; retired increments once; total EXEC cycles = 5.
REQ-030 Watchdog:
- Stimulus: next_state held at 2'b01.
- Required: fault=1 after 8 non-retiring steps; state held; all control outputs 0 thereafter.
REQ-031 Reset mid-stall:
- Stimulus: assert reset during a stalled EXEC cycle.
- Required: next cycle fetch=1, ir=0, retired=0, all controls 0.
REQ-032 Counter wrap:
- Stimulus: preload retired to 0xFFFFFFFF by forcing it in the bench, then retire one instruction.
- Required: retired=0.
REQ-033 Idle fetch:
- Stimulus: instr_valid=0 for 10 cycles.
- Required: stays in FETCH; ir unchanged; retired unchanged.
